// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared types and constants for the fetch stage
package otter_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        DONE
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/gnt/rvalid bus
interface fetch_unit_if;
    import otter_pkg::*;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_unit_timeout_ctr.sv
// rtl/fetch_unit_timeout_ctr.sv - wait-cycle counter that flags TIMEOUT expiry
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    // Holds at the terminal value so expiry stays asserted until the FSM leaves.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: one outstanding word read, IR latch, PCWrite pulse
module fetch_unit
    import otter_pkg::*;
#(
    parameter int              TIMEOUT  = 16,
    parameter logic [XLEN-1:0] RESET_IR = NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            fetch_en,
    input  logic            flush,
    input  logic            ir_ack,
    fetch_unit_if.master    mem,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc,
    output logic            ir_valid,
    output logic            pc_write,
    output logic            misalign_fault,
    output logic            fetch_fault
);
    fetch_state_e    st_q;
    logic [XLEN-1:0] addr_q;
    logic            mem_req_q;
    logic [XLEN-1:0] ir_q;
    logic [XLEN-1:0] ir_pc_q;
    logic            ir_valid_q;
    logic            pc_write_q;
    logic            misalign_q;
    logic            fetch_fault_q;

    logic ctr_clr;
    logic ctr_en;
    logic expired;

    // Window restarts while requesting and again when a flush turns WAIT into DRAIN.
    assign ctr_clr = (st_q == REQ) || ((st_q == WAIT) && flush && !mem.mem_rvalid);
    assign ctr_en  = (st_q == WAIT) || (st_q == DRAIN);

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (ctr_clr),
        .en_i      (ctr_en),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q          <= IDLE;
            addr_q        <= '0;
            mem_req_q     <= 1'b0;
            ir_q          <= RESET_IR;
            ir_pc_q       <= '0;
            ir_valid_q    <= 1'b0;
            pc_write_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            pc_write_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_fault_q <= 1'b0;
            case (st_q)
                IDLE: begin
                    if (fetch_en) begin
                        if (is_word_aligned(pc)) begin
                            addr_q    <= pc;
                            mem_req_q <= 1'b1;
                            st_q      <= REQ;
                        end else begin
                            misalign_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        st_q      <= flush ? DRAIN : WAIT;
                    end else if (flush) begin
                        mem_req_q <= 1'b0;
                        st_q      <= IDLE;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        if (flush) begin
                            st_q <= IDLE;
                        end else begin
                            ir_q       <= mem.mem_rdata;
                            ir_pc_q    <= addr_q;
                            ir_valid_q <= 1'b1;
                            pc_write_q <= 1'b1;
                            st_q       <= DONE;
                        end
                    end else if (flush) begin
                        st_q <= DRAIN;
                    end else if (expired) begin
                        fetch_fault_q <= 1'b1;
                        st_q          <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mem.mem_rvalid || expired) begin
                        st_q <= IDLE;
                    end
                end
                DONE: begin
                    if (flush) begin
                        ir_valid_q <= 1'b0;
                        st_q       <= IDLE;
                    end else if (ir_ack) begin
                        ir_valid_q <= 1'b0;
                        if (fetch_en && is_word_aligned(pc)) begin
                            addr_q    <= pc;
                            mem_req_q <= 1'b1;
                            st_q      <= REQ;
                        end else begin
                            misalign_q <= fetch_en;
                            st_q       <= IDLE;
                        end
                    end
                end
                default: begin
                    st_q <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_addr  = addr_q;
    assign ir            = ir_q;
    assign ir_pc         = ir_pc_q;
    assign ir_valid      = ir_valid_q;
    assign pc_write      = pc_write_q;
    assign misalign_fault = misalign_q;
    assign fetch_fault   = fetch_fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a transaction-level reference model
module tb_fetch_unit;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] NOPV    = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_en;
    logic        flush;
    logic        ir_ack;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        pc_write;
    logic        misalign_fault;
    logic        fetch_fault;

    fetch_unit_if mem_bus ();

    fetch_unit #(
        .TIMEOUT  (TIMEOUT),
        .RESET_IR (NOPV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .fetch_en       (fetch_en),
        .flush          (flush),
        .ir_ack         (ir_ack),
        .mem            (mem_bus),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .pc_write       (pc_write),
        .misalign_fault (misalign_fault),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the transaction (requesting / outstanding / discarding / holding).
    bit          m_requesting, m_outstanding, m_discard, m_holding;
    int          m_waited;
    logic [31:0] e_addr, e_ir, e_irpc;
    logic        e_req, e_irv, e_pw, e_mf, e_ff;

    task automatic model_start();
        if (fetch_en) begin
            if (pc % 4 == 0) begin
                m_requesting = 1; e_req = 1; e_addr = pc;
            end else begin
                e_mf = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        e_pw = 0; e_mf = 0; e_ff = 0;
        if (!reset) begin
            m_requesting = 0; m_outstanding = 0; m_discard = 0; m_holding = 0; m_waited = 0;
            e_req = 0; e_addr = 0; e_ir = NOPV; e_irpc = 0; e_irv = 0;
        end else if (m_holding) begin
            if (flush) begin
                m_holding = 0; e_irv = 0;
            end else if (ir_ack) begin
                m_holding = 0; e_irv = 0;
                model_start();
            end
        end else if (m_requesting) begin
            if (mem_bus.mem_gnt) begin
                m_requesting = 0; e_req = 0; m_outstanding = 1; m_discard = flush; m_waited = 0;
            end else if (flush) begin
                m_requesting = 0; e_req = 0;
            end
        end else if (m_outstanding) begin
            m_waited++;
            if (mem_bus.mem_rvalid) begin
                m_outstanding = 0;
                if (!m_discard && !flush) begin
                    m_holding = 1; e_ir = mem_bus.mem_rdata; e_irpc = e_addr; e_irv = 1; e_pw = 1;
                end
            end else if (flush && !m_discard) begin
                m_discard = 1; m_waited = 0;
            end else if (m_waited == TIMEOUT) begin
                m_outstanding = 0;
                if (!m_discard) e_ff = 1;
            end
        end else begin
            model_start();
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("mem_req", 32'(mem_bus.mem_req), 32'(e_req));
            if (e_req) chk("mem_addr", mem_bus.mem_addr, e_addr);
            chk("ir", ir, e_ir);
            chk("ir_pc", ir_pc, e_irpc);
            chk("ir_valid", 32'(ir_valid), 32'(e_irv));
            chk("pc_write", 32'(pc_write), 32'(e_pw));
            chk("misalign_fault", 32'(misalign_fault), 32'(e_mf));
            chk("fetch_fault", 32'(fetch_fault), 32'(e_ff));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch_to_wait(input logic [31:0] addr);
        pc = addr; fetch_en = 1; cyc();
        fetch_en = 0; mem_bus.mem_gnt = 1; cyc();
        mem_bus.mem_gnt = 0;
    endtask

    initial begin
        reset = 0; pc = 0; fetch_en = 0; flush = 0; ir_ack = 0;
        mem_bus.mem_gnt = 0; mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = 0;
        cyc();
        chk_on = 1;
        cyc();
        reset = 1;
        chk("rst_ir", ir, 32'h00000013);
        chk("rst_ir_valid", 32'(ir_valid), 0);
        chk("rst_mem_req", 32'(mem_bus.mem_req), 0);
        chk("rst_mem_addr", mem_bus.mem_addr, 0);

        // basic fetch
        pc = 32'h100; fetch_en = 1; cyc();
        chk("b_req", 32'(mem_bus.mem_req), 1);
        chk("b_addr", mem_bus.mem_addr, 32'h100);
        fetch_en = 0; mem_bus.mem_gnt = 1; cyc();
        mem_bus.mem_gnt = 0; cyc();
        mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'h00500093; cyc();
        mem_bus.mem_rvalid = 0;
        chk("b_ir", ir, 32'h00500093);
        chk("b_ir_pc", ir_pc, 32'h100);
        chk("b_ir_valid", 32'(ir_valid), 1);
        chk("b_pc_write", 32'(pc_write), 1);
        cyc();
        chk("b_pc_write_once", 32'(pc_write), 0);
        chk("b_ir_hold", 32'(ir_valid), 1);

        // back-to-back
        ir_ack = 1; fetch_en = 1; pc = 32'h104; cyc();
        ir_ack = 0; fetch_en = 0;
        chk("bb_req", 32'(mem_bus.mem_req), 1);
        chk("bb_addr", mem_bus.mem_addr, 32'h104);
        chk("bb_ir_valid", 32'(ir_valid), 0);
        mem_bus.mem_gnt = 1; cyc();
        mem_bus.mem_gnt = 0; mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'h00a00113; cyc();
        mem_bus.mem_rvalid = 0;
        chk("bb_ir", ir, 32'h00a00113);
        ir_ack = 1; cyc();
        ir_ack = 0;

        // misaligned
        pc = 32'h102; fetch_en = 1; cyc();
        fetch_en = 0;
        chk("ma_fault", 32'(misalign_fault), 1);
        chk("ma_req", 32'(mem_bus.mem_req), 0);
        cyc();
        chk("ma_pulse", 32'(misalign_fault), 0);

        // flush in WAIT, late rvalid discarded
        fetch_to_wait(32'h108);
        flush = 1; cyc();
        flush = 0; cyc(); cyc();
        mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'hDEADBEEF; cyc();
        mem_bus.mem_rvalid = 0;
        chk("fl_ir", ir, 32'h00a00113);
        chk("fl_pc_write", 32'(pc_write), 0);

        // flush together with rvalid
        fetch_to_wait(32'h10c);
        flush = 1; mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'h12345678; cyc();
        flush = 0; mem_bus.mem_rvalid = 0;
        chk("flr_ir", ir, 32'h00a00113);
        chk("flr_pc_write", 32'(pc_write), 0);

        // flush in REQ without grant
        pc = 32'h110; fetch_en = 1; cyc();
        fetch_en = 0; flush = 1; cyc();
        flush = 0;
        chk("flq_req", 32'(mem_bus.mem_req), 0);

        // timeout
        fetch_to_wait(32'h200);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            cyc();
            chk("to_early", 32'(fetch_fault), 0);
        end
        cyc();
        chk("to_fault", 32'(fetch_fault), 1);
        cyc();
        chk("to_pulse", 32'(fetch_fault), 0);
        mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'h0BADC0DE; cyc();
        mem_bus.mem_rvalid = 0;
        chk("to_stray_ir", ir, 32'h00a00113);

        // drain expiry, then a normal fetch
        fetch_to_wait(32'h400);
        flush = 1; cyc();
        flush = 0;
        for (int i = 0; i < TIMEOUT + 2; i++) cyc();
        fetch_to_wait(32'h404);
        mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'h00108093; cyc();
        mem_bus.mem_rvalid = 0;
        chk("dr_ir", ir, 32'h00108093);
        chk("dr_ir_pc", ir_pc, 32'h404);
        ir_ack = 1; cyc();
        ir_ack = 0;

        // reset mid-WAIT
        fetch_to_wait(32'h300);
        cyc();
        reset = 0; cyc();
        reset = 1;
        chk("rw_ir", ir, 32'h00000013);
        chk("rw_ir_pc", ir_pc, 0);
        mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'h11111111; cyc();
        mem_bus.mem_rvalid = 0;
        chk("rw_ir_after", ir, 32'h00000013);
        chk("rw_pc_write", 32'(pc_write), 0);
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly downstream of the program counter module.
- Takes the current PC, issues a word read to instruction memory over a req/gnt/rvalid handshake, and latches the returned word into an instruction register for decode.
- Produces the one-cycle pc_write pulse that drives the PC's PCWrite input, so the PC advances exactly once per accepted instruction.
- Handles flush (branch/trap redirect), misaligned PC and memory timeout.

Parameters:
- TIMEOUT, 16, cycles waited in WAIT for mem_rvalid before raising fetch_fault (≥2).
- RESET_IR, 32'h00000013, value loaded into ir on reset (NOP).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge)
- pc  input  32  current PC from the PC register
- fetch_en  input  1  control unit requests a fetch of pc
- flush  input  1  abandon the current fetch; the PC is being redirected
- ir_ack  input  1  decode has consumed ir
- mem_req  output  1  read request to instruction memory
- mem_addr  output  32  word address of the request (byte address, [1:0]=0)
- mem_gnt  input  1  memory accepted the request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data
- ir  output  32  latched instruction
- ir_pc  output  32  address ir was fetched from
- ir_valid  output  1  ir holds an unconsumed instruction
- pc_write  output  1  one-cycle pulse to PCWrite
- misalign_fault  output  1  one-cycle pulse: pc[1:0]!=0 at fetch start
- fetch_fault  output  1  one-cycle pulse: TIMEOUT expired

Behaviour:
- Reset: state=IDLE; mem_req=0; mem_addr=0; ir=RESET_IR; ir_pc=0; ir_valid=0; pc_write=0; both faults=0; timeout counter=0. Reset overrides every other input, including mid-transaction; memory responses arriving after reset are ignored while in IDLE.
- States: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE:
  - fetch_en=1 and pc[1:0]==0: latch addr_q=pc, go to REQ.
  - fetch_en=1 and pc[1:0]!=0: pulse misalign_fault next cycle, stay in IDLE.
- REQ:
  - mem_req=1, mem_addr=addr_q.
  - mem_gnt=1: go to WAIT, clear the counter.
  - flush=1 with mem_gnt=0: go to IDLE.
  - flush=1 with mem_gnt=1: go to DRAIN.
- WAIT:
  - mem_req=0; the counter increments each cycle.
  - mem_rvalid=1: ir<=mem_rdata, ir_pc<=addr_q, ir_valid<=1, pc_write<=1 for exactly one cycle; go to DONE. ir_valid and pc_write therefore rise on the same edge, one cycle after rvalid.
  - flush=1 without rvalid: go to DRAIN.
  - flush=1 and rvalid in the same cycle: data is discarded, go to IDLE, no pc_write.
  - Counter reaches TIMEOUT-1 without rvalid: pulse fetch_fault, go to IDLE.
- DRAIN: wait for mem_rvalid, discard the data, go to IDLE. The timeout also applies here: on expiry go to IDLE with no fault.
- DONE:
  - ir_valid held at 1 and ir stable until ir_ack.
  - ir_ack=1: ir_valid<=0. If fetch_en=1 with aligned pc in the same cycle, latch pc and go to REQ (back-to-back, no IDLE bubble); otherwise go to IDLE.
  - flush=1: ir_valid<=0, go to IDLE; flush wins over ir_ack.
- At most one outstanding request at any time. The mem_rvalid cycle is always strictly after the mem_gnt cycle.
- pc_write never asserts more than once per granted request, and never after a flush.

Decomposition:
- Shared package (otter_pkg): fetch state enum (IDLE, REQ, WAIT, DRAIN, DONE), NOP constant 32'h00000013, XLEN=32.
- Optional sub-module fetch_timeout_ctr: clear/enable/expire counter parameterised by TIMEOUT, also used in DRAIN. Everything else stays flat.

Test Plan:
- Basic fetch: reset=0 for 2 cycles, then reset=1; pc=0x100, fetch_en=1; gnt one cycle later, rvalid with 0x00500093 two cycles after that → ir=0x00500093, ir_pc=0x100, ir_valid=1, and a single-cycle pc_write on the same edge.
- Back-to-back: in DONE, ir_ack=1 and fetch_en=1 with pc=0x104 in the same cycle → mem_req=1 and mem_addr=0x104 the next cycle, ir_valid=0.
- Misaligned: pc=0x102, fetch_en=1 → misalign_fault pulses for 1 cycle, mem_req stays 0, state stays IDLE.
- Flush with grant outstanding: flush in WAIT, rvalid 3 cycles later with 0xDEADBEEF → ir is unchanged, pc_write=0, state IDLE after rvalid.
- Timeout: TIMEOUT=16, gnt given, no rvalid → fetch_fault pulses in WAIT cycle 16, then IDLE; a later stray rvalid does not change ir.
- Reset mid-WAIT: reset=0 while waiting → all outputs return to reset values next edge, ir=0x00000013; a subsequent rvalid is ignored.
